// File: rtl/ulpb_ctrl_mw.sv
// ulpb_ctrl_mw: ULPB mediator that owns the bus clock, arbitrates, receives address plus data words and runs the bus reset.
module ulpb_ctrl_mw #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_WORDS      = 4,
    parameter int CLK_DIV        = 4,
    parameter int RST_MIN_HALVES = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  DIN,
    output logic                  DOUT,
    output logic                  CLK_OUT,
    output logic [ADDR_WIDTH-1:0] RX_ADDR,
    output logic                  RX_ADDR_VALID,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic                  RX_VALID,
    output logic                  MSG_DONE,
    output logic                  MSG_ERR,
    output logic                  BUS_BUSY,
    output logic [2:0]            test_pt
);
    localparam int TOTAL = ADDR_WIDTH + MAX_WORDS * DATA_WIDTH;
    localparam int BW    = $clog2(TOTAL + 2);
    localparam int WW    = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARBI      = 3'd1,
        DRIVE     = 3'd2,
        LATCH     = 3'd3,
        RESET_SEQ = 3'd4
    } state_t;

    state_t                r_state, w_next;
    logic [1:0]            r_sync;
    logic [1:0]            r_hist;
    logic [7:0]            r_half;
    logic [7:0]            r_rcnt;
    logic                  r_clk;
    logic                  r_pend;
    logic [BW-1:0]         r_bits;
    logic [WW-1:0]         r_wcnt;
    logic [DATA_WIDTH-1:0] r_word;

    logic       w_din;
    logic       w_hend;
    logic [2:0] w_hist;
    logic       w_commit;
    logic       w_pend_set;
    logic       w_done;
    logic       w_err;

    assign w_din    = r_sync[1];
    assign w_hend   = r_state != IDLE && r_half == 8'(CLK_DIV - 1);
    assign w_hist   = {r_hist, w_din};
    assign CLK_OUT  = r_clk;
    assign BUS_BUSY = r_state != IDLE;
    assign test_pt  = r_state;

    always_comb begin
        w_next     = r_state;
        w_commit   = 1'b0;
        w_pend_set = 1'b0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        DOUT       = w_din;
        case (r_state)
            IDLE: begin
                DOUT   = 1'b1;
                w_next = w_din ? IDLE : ARBI;
            end
            ARBI: w_next = (w_hend && r_clk) ? DRIVE : ARBI;
            DRIVE: if (w_hend) begin
                w_next = r_pend ? RESET_SEQ : LATCH;
                w_done = r_pend && w_hist == 3'b010 && r_wcnt == '0 && r_bits >= BW'(ADDR_WIDTH);
                w_err  = r_pend && !w_done;
            end
            LATCH: if (w_hend) begin
                w_next = DRIVE;
                if (w_din != r_hist[0]) begin
                    w_pend_set = 1'b1;
                end else if (r_bits == BW'(TOTAL)) begin
                    w_err  = 1'b1;
                    w_next = RESET_SEQ;
                end else begin
                    w_commit = 1'b1;
                end
            end
            RESET_SEQ: begin
                DOUT   = 1'b1;
                w_next = (w_hend && r_rcnt >= 8'(RST_MIN_HALVES - 1) && w_hist[1:0] == 2'b11) ? IDLE : RESET_SEQ;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= IDLE;
            r_sync        <= 2'b11;
            r_hist        <= '0;
            r_half        <= '0;
            r_rcnt        <= '0;
            r_clk         <= 1'b1;
            r_pend        <= 1'b0;
            r_bits        <= '0;
            r_wcnt        <= '0;
            r_word        <= '0;
            RX_ADDR       <= '0;
            RX_DATA       <= '0;
            RX_ADDR_VALID <= 1'b0;
            RX_VALID      <= 1'b0;
            MSG_DONE      <= 1'b0;
            MSG_ERR       <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_sync        <= {r_sync[0], DIN};
            r_half        <= (r_state == IDLE || w_hend) ? '0 : r_half + 8'd1;
            RX_ADDR_VALID <= 1'b0;
            RX_VALID      <= 1'b0;
            MSG_DONE      <= w_done;
            MSG_ERR       <= w_err;
            if (w_hend) r_hist <= w_hist[1:0];
            // The bus clock idles high, drops to start arbitration and then flips every half.
            if (w_next == IDLE) r_clk <= 1'b1;
            else if (r_state == IDLE) r_clk <= 1'b0;
            else if (w_hend) r_clk <= ~r_clk;
            if (r_state != RESET_SEQ) r_rcnt <= '0;
            else if (w_hend && r_rcnt != 8'(RST_MIN_HALVES)) r_rcnt <= r_rcnt + 8'd1;
            if (r_state == ARBI) begin
                r_bits <= '0;
                r_wcnt <= '0;
                r_pend <= 1'b0;
            end else begin
                if (w_pend_set) r_pend <= 1'b1;
                else if (r_state == DRIVE && w_hend) r_pend <= 1'b0;
                if (w_commit) begin
                    r_bits <= r_bits + BW'(1);
                    if (r_bits < BW'(ADDR_WIDTH)) begin
                        RX_ADDR       <= {RX_ADDR[ADDR_WIDTH-2:0], w_din};
                        RX_ADDR_VALID <= r_bits == BW'(ADDR_WIDTH - 1);
                    end else begin
                        r_word <= {r_word[DATA_WIDTH-2:0], w_din};
                        r_wcnt <= (r_wcnt == WW'(DATA_WIDTH - 1)) ? '0 : r_wcnt + WW'(1);
                        if (r_wcnt == WW'(DATA_WIDTH - 1)) begin
                            RX_DATA  <= {r_word[DATA_WIDTH-2:0], w_din};
                            RX_VALID <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ulpb_ctrl_mw.sv
// tb_ulpb_ctrl_mw: table-driven bench for the ULPB mediator plus hand sequences for timeout and mid-message reset.
module tb_ulpb_ctrl_mw;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b1;
    logic        dout, clk_out, rx_addr_valid, rx_valid, msg_done, msg_err, bus_busy;
    logic [7:0]  rx_addr;
    logic [31:0] rx_data;
    logic [2:0]  test_pt;

    int n_cmp = 0, n_bad = 0;
    int n_av = 0, n_v = 0, n_d = 0, n_e = 0;
    int dout_bad = 0, run = 0, hp_min = 1000, hp_max = 0;
    int s_v, s_e, s_d;
    logic        prev_clk = 1'b1;
    logic [7:0]  last_addr = '0;
    logic [31:0] rxw [$];
    logic [7:0]  to_addr = 8'h77;
    logic [31:0] tw [4] = '{32'hFFFFFFFF, 32'h00000000, 32'hAAAAAAAA, 32'h55555555};

    typedef struct {
        logic [7:0]  addr;
        int          nab;
        int          nw;
        logic [31:0] w [4];
        int          np;
        logic [31:0] part;
        bit          bad;
        int          e_av;
        int          e_v;
        int          e_d;
        int          e_e;
    } vec_t;
    vec_t vt [7];

    ulpb_ctrl_mw dut (
        .CLK(clk), .RESET(rst), .DIN(din), .DOUT(dout), .CLK_OUT(clk_out),
        .RX_ADDR(rx_addr), .RX_ADDR_VALID(rx_addr_valid), .RX_DATA(rx_data), .RX_VALID(rx_valid),
        .MSG_DONE(msg_done), .MSG_ERR(msg_err), .BUS_BUSY(bus_busy), .test_pt(test_pt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_addr_valid) begin n_av++; last_addr = rx_addr; end
        if (rx_valid) begin n_v++; rxw.push_back(rx_data); end
        if (msg_done) n_d++;
        if (msg_err) n_e++;
        if (test_pt == 3'd4 && dout !== 1'b1) dout_bad++;
        if (clk_out !== prev_clk) begin
            if (test_pt == 3'd2 || test_pt == 3'd3) begin
                if (run < hp_min) hp_min = run;
                if (run > hp_max) hp_max = run;
            end
            run = 1;
        end else run++;
        prev_clk = clk_out;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic half(input logic v);
        din = v;
        repeat (DIV) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        half(v);
        half(v);
    endtask

    task automatic send_eom(input bit bad);
        half(1'b0);
        half(1'b1);
        half(bad ? 1'b1 : 1'b0);
    endtask

    task automatic start();
        @(negedge clk) din = 1'b0;
        @(negedge clk) din = 1'b1;
        for (int k = 0; k < 50 && test_pt != 3'd2; k++) @(negedge clk);
        #1;
        chk("enter_drive", test_pt, 3'd2);
        chk("busy_in_msg", bus_busy, 1'b1);
    endtask

    task automatic to_idle();
        din = 1'b1;
        for (int k = 0; k < 200 && test_pt != 3'd0; k++) @(negedge clk);
        #1;
        chk("idle_state", test_pt, 3'd0);
        chk("idle_clk_out", clk_out, 1'b1);
        chk("idle_dout", dout, 1'b1);
        chk("idle_busy", bus_busy, 1'b0);
    endtask

    task automatic run_vec(input int i);
        int av0, v0, d0, e0, q0;
        av0 = n_av; v0 = n_v; d0 = n_d; e0 = n_e; q0 = rxw.size();
        start();
        for (int j = 0; j < vt[i].nab; j++) send_bit(vt[i].addr[7-j]);
        for (int k = 0; k < vt[i].nw; k++)
            for (int j = 31; j >= 0; j--) send_bit(vt[i].w[k][j]);
        for (int j = vt[i].np - 1; j >= 0; j--) send_bit(vt[i].part[j]);
        send_eom(vt[i].bad);
        chk($sformatf("v%0d_state_rst_seq", i), test_pt, 3'd4);
        chk($sformatf("v%0d_addr_valid_cnt", i), n_av - av0, vt[i].e_av);
        if (vt[i].e_av > 0) chk($sformatf("v%0d_addr", i), last_addr, vt[i].addr);
        chk($sformatf("v%0d_valid_cnt", i), n_v - v0, vt[i].e_v);
        for (int k = 0; k < vt[i].e_v; k++)
            chk($sformatf("v%0d_word%0d", i, k), (q0 + k < rxw.size()) ? rxw[q0+k] : 32'hxxxxxxxx, vt[i].w[k]);
        chk($sformatf("v%0d_done", i), n_d - d0, vt[i].e_d);
        chk($sformatf("v%0d_err", i), n_e - e0, vt[i].e_e);
        to_idle();
    endtask

    initial begin
        vt[0] = '{8'hA5, 8, 1, '{32'hDEADBEEF, 0, 0, 0}, 0, 32'h0, 1'b0, 1, 1, 1, 0};
        vt[1] = '{8'h3C, 8, 4, '{32'h1, 32'h2, 32'h3, 32'h4}, 0, 32'h0, 1'b0, 1, 4, 1, 0};
        vt[2] = '{8'h81, 8, 0, '{0, 0, 0, 0}, 0, 32'h0, 1'b0, 1, 0, 1, 0};
        vt[3] = '{8'h5A, 8, 0, '{0, 0, 0, 0}, 20, 32'hABCDE, 1'b0, 1, 0, 0, 1};
        vt[4] = '{8'h0F, 8, 2, '{32'h12345678, 32'hCAFEF00D, 0, 0}, 5, 32'h15, 1'b0, 1, 2, 0, 1};
        vt[5] = '{8'hC3, 5, 0, '{0, 0, 0, 0}, 0, 32'h0, 1'b0, 0, 0, 0, 1};
        vt[6] = '{8'h96, 8, 1, '{32'h0F0F0F0F, 0, 0, 0}, 0, 32'h0, 1'b1, 1, 1, 0, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", test_pt, 3'd0);
        chk("rst_clk_out", clk_out, 1'b1);
        chk("rst_dout", dout, 1'b1);
        chk("rst_addr", rx_addr, 8'h0);
        chk("rst_data", rx_data, 32'h0);
        chk("rst_pulses", {rx_addr_valid, rx_valid, msg_done, msg_err}, 4'h0);
        chk("rst_busy", bus_busy, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_holds", test_pt, 3'd0);

        for (int i = 0; i < 7; i++) run_vec(i);

        s_v = n_v; s_e = n_e; s_d = n_d;
        start();
        for (int j = 7; j >= 0; j--) send_bit(to_addr[j]);
        for (int k = 0; k < 4; k++)
            for (int j = 31; j >= 0; j--) send_bit(tw[k][j]);
        chk("to_no_err_at_136", n_e - s_e, 0);
        send_bit(1'b1);
        chk("to_err_at_137", n_e - s_e, 1);
        chk("to_valid_cnt", n_v - s_v, 4);
        chk("to_done", n_d - s_d, 0);
        chk("to_state", test_pt, 3'd4);
        chk("to_last_word", rxw[rxw.size()-1], tw[3]);
        to_idle();

        s_v = n_v; s_e = n_e; s_d = n_d;
        start();
        half(1'b0);
        chk("fwd_dout0", dout, 1'b0);
        half(1'b0);
        half(1'b1);
        chk("fwd_dout1", dout, 1'b1);
        half(1'b1);
        for (int j = 0; j < 6; j++) send_bit(1'b1);
        for (int j = 0; j < 10; j++) send_bit(j[0]);
        @(negedge clk);
        rst = 1'b1;
        din = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_state", test_pt, 3'd0);
        chk("mid_rst_clk_out", clk_out, 1'b1);
        chk("mid_rst_dout", dout, 1'b1);
        chk("mid_rst_busy", bus_busy, 1'b0);
        chk("mid_rst_addr", rx_addr, 8'h0);
        chk("mid_rst_data", rx_data, 32'h0);
        chk("mid_rst_pulses", {rx_addr_valid, rx_valid, msg_done, msg_err}, 4'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_rst_no_msg", {n_d - s_d, n_e - s_e, n_v - s_v}, 0);
        run_vec(0);

        chk("half_period_min", hp_min, DIV);
        chk("half_period_max", hp_max, DIV);
        chk("dout_high_in_rst_seq", dout_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
